// File: rtl/base_tag_alloc.sv
// Free-list tag allocator: hands out the lowest free tag, takes tags back on retire,
// tracks the free count and flags double-frees with a sticky error.
module base_tag_alloc #(
  parameter int enc_width = 3,
  parameter int num_tags  = 2 ** enc_width
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 o_v,
  input  logic                 o_r,
  output logic [0:enc_width-1] o_tag,
  input  logic                 i_v,
  input  logic [0:enc_width-1] i_tag,
  output logic [0:enc_width]   o_free_cnt,
  output logic                 o_all_free,
  output logic                 o_err
);

  logic [0:num_tags-1]  mask_q, mask_d;
  logic [0:enc_width]   cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic [enc_width-1:0] sel_idx;
  logic                 any_free;
  logic                 alloc;
  logic                 dbl_free;
  logic                 free_ok;

  // Priority encode from registered state only; no path from o_r/i_v/i_tag.
  always_comb begin
    sel_idx  = '0;
    any_free = 1'b0;
    for (int i = num_tags - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        sel_idx  = enc_width'(i);
        any_free = 1'b1;
      end
    end
  end

  assign o_v   = any_free;
  assign o_tag = sel_idx;

  // Freeing the tag being allocated sees mask_q[i_tag]=1, so it lands here too.
  assign alloc    = any_free & o_r;
  assign dbl_free = i_v & mask_q[i_tag];
  assign free_ok  = i_v & ~mask_q[i_tag];

  always_comb begin
    mask_d = mask_q;
    if (alloc) begin
      mask_d[sel_idx] = 1'b0;
    end
    if (free_ok) begin
      mask_d[i_tag] = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({free_ok, alloc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign err_d = err_q | dbl_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '1;
      cnt_q  <= (enc_width + 1)'(num_tags);
      err_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign o_free_cnt = cnt_q;
  assign o_all_free = (cnt_q == (enc_width + 1)'(num_tags));
  assign o_err      = err_q;

endmodule

// File: tb/tb_base_tag_alloc.sv
// Directed vector table plus hand sequences and a random soak against a set model.
module tb_base_tag_alloc;
  localparam int EW = 3;
  localparam int NT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          o_v, o_r, i_v, o_all_free, o_err;
  logic [0:EW-1] o_tag, i_tag;
  logic [0:EW]   o_free_cnt;

  int total = 0;
  int bad   = 0;

  base_tag_alloc #(.enc_width(EW), .num_tags(NT)) dut (
    .clk(clk), .reset(reset), .o_v(o_v), .o_r(o_r), .o_tag(o_tag),
    .i_v(i_v), .i_tag(i_tag), .o_free_cnt(o_free_cnt),
    .o_all_free(o_all_free), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic  rst;
    logic  r;
    logic  iv;
    int    itag;
    logic  ev;
    int    etag;
    int    ecnt;
    logic  eall;
    logic  eerr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic rst, input logic r, input logic iv,
                     input int itag, input logic ev, input int etag, input int ecnt,
                     input logic eall, input logic eerr);
    vec_t v;
    v.name = nm; v.rst = rst; v.r = r; v.iv = iv; v.itag = itag;
    v.ev = ev; v.etag = etag; v.ecnt = ecnt; v.eall = eall; v.eerr = eerr;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic int lowest(input logic [NT-1:0] m);
    int r = 0;
    for (int i = NT - 1; i >= 0; i--) if (m[i]) r = i;
    return r;
  endfunction

  function automatic int popc(input logic [NT-1:0] m);
    int c = 0;
    for (int i = 0; i < NT; i++) c += int'(m[i]);
    return c;
  endfunction

  logic [NT-1:0] rm, nm;
  logic          rerr;
  logic          ralloc;
  int            rtag;

  initial begin
    reset = 1'b1; o_r = 1'b0; i_v = 1'b0; i_tag = '0;

    // name, rst, o_r, i_v, i_tag | o_v, o_tag, cnt, all_free, err
    add("reset",        1, 0, 0, 0, 1, 0, 8, 1, 0);
    add("alloc0",       0, 1, 0, 0, 1, 1, 7, 0, 0);
    add("alloc1",       0, 1, 0, 0, 1, 2, 6, 0, 0);
    add("alloc2",       0, 1, 0, 0, 1, 3, 5, 0, 0);
    add("alloc3",       0, 1, 0, 0, 1, 4, 4, 0, 0);
    add("alloc4",       0, 1, 0, 0, 1, 5, 3, 0, 0);
    add("alloc5",       0, 1, 0, 0, 1, 6, 2, 0, 0);
    add("alloc6",       0, 1, 0, 0, 1, 7, 1, 0, 0);
    add("alloc7",       0, 1, 0, 0, 0, 0, 0, 0, 0);
    add("empty_r",      0, 1, 0, 0, 0, 0, 0, 0, 0);
    add("free5",        0, 0, 1, 5, 1, 5, 1, 0, 0);
    add("free2_alloc5", 0, 1, 1, 2, 1, 2, 1, 0, 0);
    add("reset2",       1, 0, 0, 0, 1, 0, 8, 1, 0);
    add("dblfree3",     0, 0, 1, 3, 1, 0, 8, 1, 1);
    add("err_sticky",   0, 0, 0, 0, 1, 0, 8, 1, 1);
    add("reset_clr",    1, 0, 0, 0, 1, 0, 8, 1, 0);
    add("a0",           0, 1, 0, 0, 1, 1, 7, 0, 0);
    add("a1",           0, 1, 0, 0, 1, 2, 6, 0, 0);
    add("a2",           0, 1, 0, 0, 1, 3, 5, 0, 0);
    add("a3",           0, 1, 0, 0, 1, 4, 4, 0, 0);
    add("free3_alloc4", 0, 1, 1, 3, 1, 3, 4, 0, 0);
    add("reset3",       1, 0, 0, 0, 1, 0, 8, 1, 0);
    add("b0",           0, 1, 0, 0, 1, 1, 7, 0, 0);
    add("b1",           0, 1, 0, 0, 1, 2, 6, 0, 0);
    add("b2",           0, 1, 0, 0, 1, 3, 5, 0, 0);
    add("b3",           0, 1, 0, 0, 1, 4, 4, 0, 0);
    add("b4",           0, 1, 0, 0, 1, 5, 3, 0, 0);
    add("b5",           0, 1, 0, 0, 1, 6, 2, 0, 0);
    add("reset_prio",   1, 1, 1, 1, 1, 0, 8, 1, 0);
    add("free_own_tag", 0, 1, 1, 0, 1, 1, 7, 0, 1);

    foreach (vecs[k]) begin
      @(negedge clk);
      reset = vecs[k].rst; o_r = vecs[k].r; i_v = vecs[k].iv;
      i_tag = EW'(vecs[k].itag);
      @(posedge clk);
      #1;
      check({vecs[k].name, ".o_v"},   int'(o_v),        int'(vecs[k].ev));
      check({vecs[k].name, ".o_tag"}, int'(o_tag),      vecs[k].etag);
      check({vecs[k].name, ".cnt"},   int'(o_free_cnt), vecs[k].ecnt);
      check({vecs[k].name, ".all"},   int'(o_all_free), int'(vecs[k].eall));
      check({vecs[k].name, ".err"},   int'(o_err),      int'(vecs[k].eerr));
    end

    // o_v/o_tag must not react to same-cycle inputs
    @(negedge clk);
    reset = 1'b1; o_r = 1'b0; i_v = 1'b0;
    @(negedge clk);
    reset = 1'b0; o_r = 1'b1; i_v = 1'b1; i_tag = 3'd0;
    #1;
    check("comb_iso.o_v", int'(o_v), 1);
    check("comb_iso.o_tag", int'(o_tag), 0);
    @(negedge clk);
    o_r = 1'b0; i_v = 1'b0;

    // No bypass: drain, then a free must not show up before the edge
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; o_r = 1'b1;
    repeat (8) @(negedge clk);
    o_r = 1'b0; i_v = 1'b1; i_tag = 3'd6;
    #1;
    check("nobypass.o_v", int'(o_v), 0);
    check("nobypass.o_tag", int'(o_tag), 0);
    @(posedge clk);
    #1;
    check("free6.o_v", int'(o_v), 1);
    check("free6.o_tag", int'(o_tag), 6);
    @(negedge clk);
    i_v = 1'b0;

    // Random soak against a set model
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rm = '1; rerr = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      o_r = 1'($urandom_range(0, 1));
      i_v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0 || rm == '1) i_tag = EW'($urandom_range(0, NT - 1));
      else begin
        int t;
        t = $urandom_range(0, NT - 1);
        for (int j = 0; j < NT; j++) if (rm[(t + j) % NT] == 1'b0) begin
          i_tag = EW'((t + j) % NT);
          break;
        end
      end
      rtag   = lowest(rm);
      ralloc = (rm != '0) && o_r;
      nm = rm;
      if (ralloc) nm[rtag] = 1'b0;
      if (i_v && rm[int'(i_tag)]) rerr = 1'b1;
      if (i_v && !rm[int'(i_tag)]) nm[int'(i_tag)] = 1'b1;
      rm = nm;
      @(posedge clk);
      #1;
      if (o_v !== (rm != '0) || o_free_cnt !== (EW+1)'(popc(rm)) || o_err !== rerr ||
          (rm != '0 && int'(o_tag) != lowest(rm)) || (rm == '0 && o_tag !== '0)) begin
        check("soak.tag", int'(o_tag), (rm != '0) ? lowest(rm) : 0);
        check("soak.cnt", int'(o_free_cnt), popc(rm));
        check("soak.err", int'(o_err), int'(rerr));
        check("soak.v", int'(o_v), int'(rm != '0));
      end else begin
        total++;
      end
      @(negedge clk);
    end
    o_r = 1'b0; i_v = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
